// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor: one BCD digit per clock, least significant digit first,
// using a single binary-add-plus-6-correction slice, with a start/busy/done handshake.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] in_a,
    input  logic [4*DIGITS-1:0] in_b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out,
    output logic                sum_val
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   opA;
    logic [W-1:0]   opB;
    logic [W-1:0]   acc;
    logic           opMode;
    logic           carry;
    logic           invalid;
    logic [IW-1:0]  idx;

    logic [3:0]     digA;
    logic [3:0]     digB;
    logic [3:0]     bEff;
    logic [4:0]     rawSum;
    logic           corr;
    logic [3:0]     digOut;
    logic           digBad;
    logic [W-1:0]   nextAcc;

    // Operands shift right one digit per RUN edge, so the active digit is always [3:0].
    always_comb begin
        digA    = opA[3:0];
        digB    = opB[3:0];
        bEff    = opMode ? (4'd9 - digB) : digB;
        rawSum  = {1'b0, digA} + {1'b0, bEff} + {4'b0000, carry};
        corr    = (rawSum > 5'd9);
        digOut  = corr ? (rawSum[3:0] + 4'd6) : rawSum[3:0];
        digBad  = (digA[3] & (digA[2] | digA[1])) | (digB[3] & (digB[2] | digB[1]));
        nextAcc = (acc >> 4) | (W'(digOut) << (W - 4));
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opA       <= '0;
            opB       <= '0;
            acc       <= '0;
            opMode    <= 1'b0;
            carry     <= 1'b0;
            invalid   <= 1'b0;
            idx       <= '0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            sum_val   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opA     <= in_a;
                        opB     <= in_b;
                        opMode  <= mode;
                        carry   <= carry_in;
                        acc     <= '0;
                        idx     <= '0;
                        invalid <= 1'b0;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    opA     <= opA >> 4;
                    opB     <= opB >> 4;
                    acc     <= nextAcc;
                    carry   <= corr;
                    invalid <= invalid | digBad;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        sum       <= nextAcc;
                        carry_out <= corr;
                        sum_val   <= ~(invalid | digBad);
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
